nf_seven_seg_scan_ctrl: RTL and testbench

//  Scan scheduler for the multiplexed 4-digit seven-segment display on board tops.
//  - Holds the displayed 32-bit value; CPU/GPIO-side updates use a req/ack handshake
//    and take effect only at frame boundaries, so no tearing.
//  - Sequences the digit strobes with dead-time blanking (anti-ghosting),
//    4-bit PWM brightness and optional leading-zero blanking.
//  - Drives the board pins through the existing nf_seven_seg decoder.

---
 rtl/nf_hex_pkg.sv | 26 ++
 rtl/nf_seven_seg.sv | 44 ++++
 rtl/nf_seven_seg_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_nf_seven_seg_scan_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf_hex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nf_hex_pkg
//  Description : Shared types and helpers for the seven-segment scan path.
//                - scan_state_e : digit-slot phase (dead-time blank / show)
//                - NF_DIGITS    : number of multiplexed digits on the board
//                - seg_off()    : all-segments-dark pattern for a polarity
//  Revision    : 1.0  initial release
// ============================================================================
package nf_hex_pkg;

    localparam int NF_DIGITS = 4;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Common cathode drives segments active-high, so dark is all zeros;
    // common anode is the inverse.
    function automatic logic [7:0] seg_off(input logic cc_ca);
        return cc_ca ? 8'h00 : 8'hFF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nf_seven_seg.sv
`default_nettype none
// ============================================================================
//  Module      : nf_seven_seg
//  Description : Hex nibble to seven-segment pattern decoder.
//                Bit order {dp,g,f,e,d,c,b,a}; the decimal point is never lit.
//  Ports       : hex       in  4  nibble to display
//                cc_ca     in  1  1 = common cathode (active-high segments),
//                                 0 = common anode (active-low segments)
//                seven_seg out 8  segment pattern in the selected polarity
//  Revision    : 1.0  initial release
// ============================================================================
module nf_seven_seg (
    input  logic [3:0] hex,
    input  logic       cc_ca,
    output logic [7:0] seven_seg
);

    logic [7:0] seg_hi;

    always_comb begin
        seg_hi = 8'h00;
        case (hex)
            4'h0:    seg_hi = 8'h3F;
            4'h1:    seg_hi = 8'h06;
            4'h2:    seg_hi = 8'h5B;
            4'h3:    seg_hi = 8'h4F;
            4'h4:    seg_hi = 8'h66;
            4'h5:    seg_hi = 8'h6D;
            4'h6:    seg_hi = 8'h7D;
            4'h7:    seg_hi = 8'h07;
            4'h8:    seg_hi = 8'h7F;
            4'h9:    seg_hi = 8'h6F;
            4'hA:    seg_hi = 8'h77;
            4'hB:    seg_hi = 8'h7C;
            4'hC:    seg_hi = 8'h39;
            4'hD:    seg_hi = 8'h5E;
            4'hE:    seg_hi = 8'h79;
            default: seg_hi = 8'h71;
        endcase
        seven_seg = cc_ca ? seg_hi : ~seg_hi;
    end

endmodule
`default_nettype wire

// File: rtl/nf_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nf_seven_seg_scan_ctrl
//  Description : Scan scheduler for a multiplexed 4-digit seven-segment
//                display. Each digit slot starts with BLANK_CYC dead-time
//                cycles (all digits off) followed by the show phase, where the
//                digit is PWM-gated by a 4-bit brightness and optionally
//                leading-zero blanked. Value updates arrive via req/ack and
//                are applied only at the end of a full frame (no tearing).
//  Ports       : clk        in  1   clock
//                resetn     in  1   asynchronous reset, active low
//                wr_req     in  1   update request, held until wr_ack
//                wr_data    in  32  new value, nibble i -> digit i
//                wr_ack     out 1   one-cycle pulse, wr_data latched
//                brightness in  4   0 = dark .. 15 = always on
//                lz_en      in  1   leading-zero blanking enable
//                cc_ca      in  1   1 = common cathode, 0 = common anode
//                seven_seg  out 8   segment outputs
//                dig        out 4   digit strobes, active-low one-hot
//  Revision    : 1.0  initial release
// ============================================================================
module nf_seven_seg_scan_ctrl
    import nf_hex_pkg::*;
#(
    parameter int SLOT_CYC  = 2**17,
    parameter int BLANK_CYC = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_req,
    input  logic [31:0] wr_data,
    output logic        wr_ack,
    input  logic [3:0]  brightness,
    input  logic        lz_en,
    input  logic        cc_ca,
    output logic [7:0]  seven_seg,
    output logic [3:0]  dig
);

    localparam int                SLOT_W     = $clog2(SLOT_CYC);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOT_CYC - 1);
    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYC - 1);
    // 15-step PWM period so brightness 15 means "lit on every step".
    localparam logic [3:0]        PWM_LAST   = 4'd14;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    scan_state_e       state_q,    state_d;
    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [3:0]        pwm_cnt_q,  pwm_cnt_d;
    logic [1:0]        idx_q,      idx_d;
    logic [3:0]        bri_q,      bri_d;
    logic [31:0]       value_q,    value_d;
    logic              ack_done_q, ack_done_d;
    logic [3:0]        dig_q,      dig_d;
    logic [7:0]        seg_q,      seg_d;
    logic              lit_q,      lit_d;

    logic              frame_end;
    logic [3:0]        cur_nibble;
    logic [7:0]        dec_seg;
    logic [NF_DIGITS-1:0] lz_blank;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_BLANK;
            slot_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            idx_q      <= '0;
            bri_q      <= '0;
            value_q    <= '0;
            ack_done_q <= 1'b0;
            dig_q      <= 4'hF;
            seg_q      <= 8'h00;
            lit_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            idx_q      <= idx_d;
            bri_q      <= bri_d;
            value_q    <= value_d;
            ack_done_q <= ack_done_d;
            dig_q      <= dig_d;
            seg_q      <= seg_d;
            lit_q      <= lit_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: slot/PWM counters, digit index, brightness snapshot
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        slot_cnt_d = (slot_cnt_q == SLOT_LAST) ? '0 : slot_cnt_q + SLOT_W'(1);
        pwm_cnt_d  = pwm_cnt_q;
        idx_d      = idx_q;
        bri_d      = bri_q;
        case (state_q)
            ST_BLANK: begin
                if (slot_cnt_q == BLANK_LAST) begin
                    state_d   = ST_SHOW;
                    // Brightness is frozen per slot so a change never
                    // alters the duty of the digit currently on.
                    bri_d     = brightness;
                    pwm_cnt_d = '0;
                end
            end
            ST_SHOW: begin
                pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? 4'd0 : pwm_cnt_q + 4'd1;
                if (slot_cnt_q == SLOT_LAST) begin
                    state_d = ST_BLANK;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // ------------------------------------------------------------------
    // Value update handshake. Acks only at frame end so the whole frame
    // shows one consistent value. ack_done_q stops a requester that keeps
    // wr_req high from being acked again until it drops the request.
    // ------------------------------------------------------------------
    assign frame_end = (state_q == ST_SHOW) && (idx_q == 2'd3) &&
                       (slot_cnt_q == SLOT_LAST);
    assign wr_ack    = frame_end && wr_req && !ack_done_q;

    always_comb begin
        value_d    = wr_ack ? wr_data : value_q;
        ack_done_d = ack_done_q;
        if (wr_ack) begin
            ack_done_d = 1'b1;
        end else if (!wr_req) begin
            ack_done_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero mask: digit i>0 is dark when it and every higher
    // nibble are zero. Digit 0 always shows so a zero value reads "0".
    // ------------------------------------------------------------------
    assign lz_blank[0] = 1'b0;
    for (genvar gi = 1; gi < NF_DIGITS; gi++) begin : g_lz
        assign lz_blank[gi] = lz_en && (value_q[31:gi*4] == '0);
    end

    // ------------------------------------------------------------------
    // Nibble decode
    // ------------------------------------------------------------------
    assign cur_nibble = value_q[{idx_q, 2'b00} +: 4];

    nf_seven_seg u_dec (
        .hex       (cur_nibble),
        .cc_ca     (cc_ca),
        .seven_seg (dec_seg)
    );

    // ------------------------------------------------------------------
    // Output decode (registered one cycle later)
    // ------------------------------------------------------------------
    always_comb begin
        lit_d = (state_q == ST_SHOW) && (pwm_cnt_q < bri_q) && !lz_blank[idx_q];
        dig_d = lit_d ? ~(4'b0001 << idx_q) : 4'hF;
        seg_d = lit_d ? dec_seg : 8'h00;
    end

    // The dark pattern follows cc_ca directly so reset and blanking show
    // the correct off level for either display type without a reset value
    // that depends on an input pin.
    assign dig       = dig_q;
    assign seven_seg = lit_q ? seg_q : seg_off(cc_ca);

endmodule
`default_nettype wire

// File: tb/tb_nf_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nf_seven_seg_scan_ctrl
//  Description : Directed self-checking bench for nf_seven_seg_scan_ctrl
//                with SLOT_CYC=32, BLANK_CYC=4 (one frame = 128 cycles).
//                cyc counts rising edges since reset release; the internal
//                slot position during cycle n is n%32, digit (n/32)%4, and
//                the registered outputs seen at cycle n reflect cycle n-1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nf_seven_seg_scan_ctrl;

    logic        clk;
    logic        resetn;
    logic        wr_req;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic [3:0]  brightness;
    logic        lz_en;
    logic        cc_ca;
    logic [7:0]  seven_seg;
    logic [3:0]  dig;

    int vectors;
    int miscompares;
    int cyc;

    nf_seven_seg_scan_ctrl #(
        .SLOT_CYC  (32),
        .BLANK_CYC (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .brightness (brightness),
        .lz_en      (lz_en),
        .cc_ca      (cc_ca),
        .seven_seg  (seven_seg),
        .dig        (dig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset(input logic [3:0] bri, input logic lz, input logic cc);
        @(negedge clk);
        resetn     = 1'b0;
        wr_req     = 1'b0;
        wr_data    = 32'h0;
        brightness = bri;
        lz_en      = lz;
        cc_ca      = cc;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Asynchronous reset mid-show, then latency to the first strobe.
    task automatic test_reset();
        int n;
        do_reset(4'hF, 1'b0, 1'b1);
        wait_to(40);
        wr_req = 1'b1;
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        vectors++;
        if (dig !== 4'hF) begin
            miscompares++; $display("FAIL reset_dig: got %h expected %h", dig, 4'hF);
        end
        vectors++;
        if (seven_seg !== 8'h00) begin
            miscompares++; $display("FAIL reset_seg: got %h expected %h", seven_seg, 8'h00);
        end
        vectors++;
        if (wr_ack !== 1'b0) begin
            miscompares++; $display("FAIL reset_ack: got %b expected 0", wr_ack);
        end
        wr_req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (dig === 4'hE) begin
                n = k;
                break;
            end
        end
        vectors++;
        if (n !== 5) begin
            miscompares++; $display("FAIL reset_first_strobe: got %0d cycles expected 5", n);
        end
        vectors++;
        if (seven_seg !== 8'h3F) begin
            miscompares++; $display("FAIL reset_first_seg: got %h expected %h", seven_seg, 8'h3F);
        end
    endtask

    // Frame-boundary update with the request held for three frames.
    task automatic test_write();
        int acks;
        int ack_at;
        acks   = 0;
        ack_at = -1;
        do_reset(4'hF, 1'b0, 1'b1);
        wait_to(50);
        wr_data = 32'h1234ABCD;
        wr_req  = 1'b1;
        while (cyc < 50 + 3*128) begin
            if (wr_ack === 1'b1) begin
                acks++;
                ack_at = cyc;
            end
            if (cyc == 110) begin
                vectors++;
                if (dig !== 4'h7 || seven_seg !== 8'h3F) begin
                    miscompares++; $display("FAIL write_old_value: got dig %h seg %h expected dig 7 seg 3f", dig, seven_seg);
                end
            end
            if (cyc == 140) begin
                vectors++;
                if (dig !== 4'hE || seven_seg !== 8'h5E) begin
                    miscompares++; $display("FAIL write_digit0: got dig %h seg %h expected dig e seg 5e", dig, seven_seg);
                end
            end
            if (cyc == 172) begin
                vectors++;
                if (dig !== 4'hD || seven_seg !== 8'h39) begin
                    miscompares++; $display("FAIL write_digit1: got dig %h seg %h expected dig d seg 39", dig, seven_seg);
                end
            end
            if (cyc == 204) begin
                vectors++;
                if (dig !== 4'hB || seven_seg !== 8'h7C) begin
                    miscompares++; $display("FAIL write_digit2: got dig %h seg %h expected dig b seg 7c", dig, seven_seg);
                end
            end
            if (cyc == 236) begin
                vectors++;
                if (dig !== 4'h7 || seven_seg !== 8'h77) begin
                    miscompares++; $display("FAIL write_digit3: got dig %h seg %h expected dig 7 seg 77", dig, seven_seg);
                end
            end
            @(negedge clk);
        end
        wr_req = 1'b0;
        vectors++;
        if (acks !== 1) begin
            miscompares++; $display("FAIL write_ack_count: got %0d expected 1", acks);
        end
        vectors++;
        if (ack_at !== 127) begin
            miscompares++; $display("FAIL write_ack_cycle: got %0d expected 127", ack_at);
        end
    endtask

    // Duty cycle at brightness 15, 0 and 7.
    task automatic test_brightness();
        int lit;
        int s;
        logic [3:0] exp_dig;
        do_reset(4'hF, 1'b0, 1'b1);
        lit = 0;
        wait_to(33);
        while (cyc <= 64) begin
            if (dig !== 4'hF) lit++;
            if (cyc == 40) begin
                vectors++;
                if (dig !== 4'hD) begin
                    miscompares++; $display("FAIL bri15_digit1: got %h expected %h", dig, 4'hD);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (lit !== 28) begin
            miscompares++; $display("FAIL bri15_lit_count: got %0d expected 28", lit);
        end

        do_reset(4'h0, 1'b0, 1'b1);
        lit = 0;
        wait_to(1);
        while (cyc <= 128) begin
            if (dig !== 4'hF) lit++;
            @(negedge clk);
        end
        vectors++;
        if (lit !== 0) begin
            miscompares++; $display("FAIL bri0_lit_count: got %0d expected 0", lit);
        end

        do_reset(4'h7, 1'b0, 1'b1);
        wait_to(1);
        while (cyc <= 32) begin
            s = cyc - 1;
            exp_dig = (s >= 4 && ((s - 4) % 15) < 7) ? 4'hE : 4'hF;
            vectors++;
            if (dig !== exp_dig) begin
                miscompares++; $display("FAIL bri7_slot%0d: got %h expected %h", s, dig, exp_dig);
            end
            @(negedge clk);
        end
    endtask

    // Leading-zero blanking for 0 and 0x000000A0.
    task automatic test_lz();
        logic seen;
        seen = 1'b0;
        do_reset(4'hF, 1'b1, 1'b1);
        wait_to(1);
        wr_data = 32'h000000A0;
        wr_req  = 1'b1;
        while (cyc <= 240) begin
            if (seen) wr_req = 1'b0;
            if (wr_ack === 1'b1) seen = 1'b1;
            if (cyc == 10 || cyc == 138) begin
                vectors++;
                if (dig !== 4'hE || seven_seg !== 8'h3F) begin
                    miscompares++; $display("FAIL lz_digit0_c%0d: got dig %h seg %h expected dig e seg 3f", cyc, dig, seven_seg);
                end
            end
            if (cyc == 42 || cyc == 74 || cyc == 106 || cyc == 202 || cyc == 234) begin
                vectors++;
                if (dig !== 4'hF || seven_seg !== 8'h00) begin
                    miscompares++; $display("FAIL lz_blank_c%0d: got dig %h seg %h expected dig f seg 00", cyc, dig, seven_seg);
                end
            end
            if (cyc == 170) begin
                vectors++;
                if (dig !== 4'hD || seven_seg !== 8'h77) begin
                    miscompares++; $display("FAIL lz_digit1_A: got dig %h seg %h expected dig d seg 77", dig, seven_seg);
                end
            end
            @(negedge clk);
        end
        wr_req = 1'b0;
    endtask

    // Display polarity switch during blanking.
    task automatic test_polarity();
        do_reset(4'hF, 1'b0, 1'b1);
        wait_to(1);
        vectors++;
        if (seven_seg !== 8'h00) begin
            miscompares++; $display("FAIL pol_off_cc: got %h expected %h", seven_seg, 8'h00);
        end
        cc_ca = 1'b0;
        #1;
        vectors++;
        if (seven_seg !== 8'hFF) begin
            miscompares++; $display("FAIL pol_off_ca: got %h expected %h", seven_seg, 8'hFF);
        end
        wait_to(3);
        vectors++;
        if (dig !== 4'hF || seven_seg !== 8'hFF) begin
            miscompares++; $display("FAIL pol_blank_ca: got dig %h seg %h expected dig f seg ff", dig, seven_seg);
        end
        wait_to(10);
        vectors++;
        if (dig !== 4'hE || seven_seg !== 8'hC0) begin
            miscompares++; $display("FAIL pol_lit_ca: got dig %h seg %h expected dig e seg c0", dig, seven_seg);
        end
        cc_ca = 1'b1;
    endtask

    // Brightness change mid-show and a cancelled write request.
    task automatic test_bri_change();
        int lit;
        int acks;
        do_reset(4'hF, 1'b0, 1'b1);
        wait_to(10);
        brightness = 4'd3;
        lit = 0;
        while (cyc <= 32) begin
            if (dig !== 4'hF) lit++;
            @(negedge clk);
        end
        vectors++;
        if (lit !== 23) begin
            miscompares++; $display("FAIL bri_cur_slot: got %0d lit expected 23", lit);
        end
        lit = 0;
        while (cyc <= 64) begin
            if (dig !== 4'hF) lit++;
            @(negedge clk);
        end
        vectors++;
        if (lit !== 6) begin
            miscompares++; $display("FAIL bri_next_slot: got %0d lit expected 6", lit);
        end
        wr_data = 32'hFFFFFFFF;
        wr_req  = 1'b1;
        acks    = 0;
        while (cyc <= 200) begin
            if (cyc == 120) wr_req = 1'b0;
            if (wr_ack === 1'b1) acks++;
            if (cyc == 133) begin
                vectors++;
                if (dig !== 4'hE || seven_seg !== 8'h3F) begin
                    miscompares++; $display("FAIL cancel_value: got dig %h seg %h expected dig e seg 3f", dig, seven_seg);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (acks !== 0) begin
            miscompares++; $display("FAIL cancel_ack: got %0d acks expected 0", acks);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        wr_req      = 1'b0;
        wr_data     = 32'h0;
        brightness  = 4'hF;
        lz_en       = 1'b0;
        cc_ca       = 1'b1;
        test_reset();
        test_write();
        test_brightness();
        test_lz();
        test_polarity();
        test_bri_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
